// File: rtl/stim_sequencer_if.sv
// stim_sequencer_if
// Bundles the control inputs and the vector bus of the stimulus sequencer.
//   master : test controller side, drives start/mode/num_vectors/hold
//   slave  : sequencer side, drives vec_out/vec_valid/vec_index/busy/done
// Signals:
//   start        begin a run (only looked at while the sequencer is idle)
//   mode         pattern select, captured together with start
//   num_vectors  run length, captured together with start
//   hold         freeze the current vector for this cycle
//   vec_out      current stimulus vector
//   vec_valid    vec_out belongs to the current run
//   vec_index    0-based position of vec_out within the run
//   busy         a run is in progress
//   done         one-cycle completion pulse
interface stim_sequencer_if #(
    parameter int WIDTH   = 6,
    parameter int COUNT_W = 16
) ();
    logic               start;
    logic [1:0]         mode;
    logic [COUNT_W-1:0] num_vectors;
    logic               hold;
    logic [WIDTH-1:0]   vec_out;
    logic               vec_valid;
    logic [COUNT_W-1:0] vec_index;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, num_vectors, hold,
        input  vec_out, vec_valid, vec_index, busy, done
    );

    modport slave (
        input  start, mode, num_vectors, hold,
        output vec_out, vec_valid, vec_index, busy, done
    );
endinterface

// File: rtl/stim_sequencer.sv
// stim_sequencer
// Emits a bounded run of stimulus vectors in one of four patterns
// (increment, decrement, walking one, Galois LFSR), with a stall input
// and a one-cycle completion pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    stim_sequencer_if slave modport (control in, vector bus out)
// Parameters:
//   WIDTH      vector width in bits (>= 2)
//   COUNT_W    width of the run-length and index counters
//   LFSR_TAPS  Galois feedback mask used in LFSR mode
module stim_sequencer #(
    parameter int               WIDTH     = 6,
    parameter int               COUNT_W   = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 6'h30
) (
    input  logic            clk,
    input  logic            reset,
    stim_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'b00;
    localparam logic [1:0] MODE_DEC   = 2'b01;
    localparam logic [1:0] MODE_WALK1 = 2'b10;

    state_t             state;
    logic [1:0]         mode_q;
    logic [COUNT_W-1:0] num_q;
    logic [WIDTH-1:0]   vec_q;
    logic [COUNT_W-1:0] index_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    // First vector of a run for the given pattern.
    function automatic logic [WIDTH-1:0] first_value(input logic [1:0] m);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_INC: v = '0;
            MODE_DEC: v = '1;
            default:  v = WIDTH'(1);
        endcase
        return v;
    endfunction

    // Successor of v for the given pattern.
    function automatic logic [WIDTH-1:0] next_value(input logic [1:0] m,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        case (m)
            MODE_INC:   n = v + WIDTH'(1);
            MODE_DEC:   n = v - WIDTH'(1);
            MODE_WALK1: n = {v[WIDTH-2:0], v[WIDTH-1]};
            default:    n = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
        endcase
        return n;
    endfunction

    // Single FSM with all outputs registered. mode and num_vectors are
    // captured on start so the controller may change them during a run.
    // A zero-length run goes straight to DONE so the controller still gets
    // its completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= '0;
            num_q   <= '0;
            vec_q   <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        num_q  <= bus.num_vectors;
                        if (bus.num_vectors != '0) begin
                            state   <= RUN;
                            vec_q   <= first_value(bus.mode);
                            index_q <= '0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        if (index_q == num_q - COUNT_W'(1)) begin
                            // Last vector consumed; vec/index keep their value.
                            state   <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q   <= next_value(mode_q, vec_q);
                            index_q <= index_q + COUNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.vec_valid = valid_q;
    assign bus.vec_index = index_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer
// Directed self-checking bench for stim_sequencer (WIDTH=6, COUNT_W=16,
// LFSR_TAPS=6'h30). Inputs change 1 ns after a rising edge, right after
// the outputs for that cycle are sampled.
module tb_stim_sequencer;

    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;
    bit   seen [64];

    stim_sequencer_if #(.WIDTH(6), .COUNT_W(16)) bus ();

    stim_sequencer #(
        .WIDTH(6),
        .COUNT_W(16),
        .LFSR_TAPS(6'h30)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // A valid run vector with the given value and index.
    task automatic check_vec(input string tag, input logic [5:0] v,
                             input logic [15:0] idx);
        check({tag, "_vec"},   32'(bus.vec_out),   32'(v));
        check({tag, "_idx"},   32'(bus.vec_index), 32'(idx));
        check({tag, "_valid"}, 32'(bus.vec_valid), 32'd1);
        check({tag, "_busy"},  32'(bus.busy),      32'd1);
        check({tag, "_done"},  32'(bus.done),      32'd0);
    endtask

    task automatic check_flags(input string tag, input logic valid,
                               input logic busy, input logic done);
        check({tag, "_valid"}, 32'(bus.vec_valid), 32'(valid));
        check({tag, "_busy"},  32'(bus.busy),      32'(busy));
        check({tag, "_done"},  32'(bus.done),      32'(done));
    endtask

    task automatic apply_stimulus(input logic [1:0] m, input logic [15:0] n);
        bus.mode        = m;
        bus.num_vectors = n;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    initial begin
        logic [5:0] lfsr_exp [7];
        logic [5:0] walk_exp [8];
        lfsr_exp = '{6'h01, 6'h30, 6'h18, 6'h0C, 6'h06, 6'h03, 6'h31};
        walk_exp = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01, 6'h02};
        assert_count = 0;
        fail_count   = 0;

        // Reset with start held high: no run may begin.
        reset           = 1'b1;
        bus.start       = 1'b1;
        bus.mode        = 2'b00;
        bus.num_vectors = 16'd5;
        bus.hold        = 1'b0;
        step();
        step();
        check("rst_vec", 32'(bus.vec_out), 32'd0);
        check("rst_idx", 32'(bus.vec_index), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        check_flags("post_rst", 1'b0, 1'b0, 1'b0);
        $display("[TB] reset checks complete");

        // INC, 70 vectors: 0..63 then wraps to 0..5.
        apply_stimulus(2'b00, 16'd70);
        for (int i = 0; i < 70; i++) begin
            check_vec("inc", 6'(i % 64), 16'(i));
            step();
        end
        check_flags("inc_end", 1'b0, 1'b0, 1'b1);
        check("inc_end_vec", 32'(bus.vec_out), 32'h05);
        check("inc_end_idx", 32'(bus.vec_index), 32'd69);
        step();
        check_flags("inc_idle", 1'b0, 1'b0, 1'b0);

        // DEC, 3 vectors, hold asserted two cycles while 3E is shown.
        apply_stimulus(2'b01, 16'd3);
        check_vec("dec0", 6'h3F, 16'd0);
        step();
        check_vec("dec1", 6'h3E, 16'd1);
        bus.hold = 1'b1;
        step();
        check_vec("dec1_hold_a", 6'h3E, 16'd1);
        step();
        check_vec("dec1_hold_b", 6'h3E, 16'd1);
        bus.hold = 1'b0;
        step();
        check_vec("dec2", 6'h3D, 16'd2);
        step();
        check_flags("dec_end", 1'b0, 1'b0, 1'b1);
        check("dec_end_vec", 32'(bus.vec_out), 32'h3D);
        step();

        // WALK1, 8 vectors: MSB rotates back to bit 0.
        apply_stimulus(2'b10, 16'd8);
        for (int i = 0; i < 8; i++) begin
            check_vec("walk", walk_exp[i], 16'(i));
            step();
        end
        check_flags("walk_end", 1'b0, 1'b0, 1'b1);
        step();

        // LFSR, 64 vectors: 63 distinct nonzero values then 01 again.
        apply_stimulus(2'b11, 16'd64);
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < 7) check_vec("lfsr_seq", lfsr_exp[i], 16'(i));
            if (i < 63) begin
                check("lfsr_nonzero", 32'(bus.vec_out != 6'h00), 32'd1);
                check("lfsr_distinct", 32'(seen[bus.vec_out]), 32'd0);
                seen[bus.vec_out] = 1'b1;
            end else begin
                check_vec("lfsr_repeat", 6'h01, 16'd63);
            end
            step();
        end
        check_flags("lfsr_end", 1'b0, 1'b0, 1'b1);
        step();

        // Zero-length run: no valid vector, single done pulse.
        apply_stimulus(2'b00, 16'd0);
        check_flags("n0_done", 1'b0, 1'b0, 1'b1);
        step();
        check_flags("n0_idle", 1'b0, 1'b0, 1'b0);
        step();
        check_flags("n0_idle2", 1'b0, 1'b0, 1'b0);

        // start and input changes during RUN are ignored; reset at index 4.
        apply_stimulus(2'b00, 16'd10);
        check_vec("r6_0", 6'd0, 16'd0);
        step();
        check_vec("r6_1", 6'd1, 16'd1);
        step();
        check_vec("r6_2", 6'd2, 16'd2);
        bus.start       = 1'b1;
        bus.mode        = 2'b10;
        bus.num_vectors = 16'd3;
        step();
        bus.start = 1'b0;
        check_vec("r6_3", 6'd3, 16'd3);
        step();
        check_vec("r6_4", 6'd4, 16'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r6_rst_vec", 32'(bus.vec_out), 32'd0);
        check("r6_rst_idx", 32'(bus.vec_index), 32'd0);
        check_flags("r6_rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_flags("r6_no_done", 1'b0, 1'b0, 1'b0);
        end

        // A fresh run after the mid-run reset behaves normally.
        apply_stimulus(2'b00, 16'd2);
        check_vec("r7_0", 6'd0, 16'd0);
        step();
        check_vec("r7_1", 6'd1, 16'd1);
        step();
        check_flags("r7_end", 1'b0, 1'b0, 1'b1);
        step();
        check_flags("r7_idle", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
